// File: rtl/tick_scheduler.sv
// Run-control sequencer for the free-running period counter: start/stop/pause,
// one-shot runs, and period updates that only land on a tick boundary.
module tick_scheduler #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50_000_000,
  parameter int          COUNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               one_shot,
  input  logic               cfg_valid,
  input  logic [31:0]        cfg_period,
  output logic               cfg_ready,
  output logic               tick,
  output logic               done,
  output logic               running,
  output logic               paused,
  output logic [31:0]        period,
  output logic [COUNT_W-1:0] tick_count,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          counter_q, counter_d;
  logic [31:0]          period_q, period_d;
  logic [31:0]          pending_period_q, pending_period_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 shot_mode_q, shot_mode_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic [COUNT_W-1:0]   tick_count_q, tick_count_d;

  logic                 xfer;
  logic [31:0]          last_count;

  // Config handshake: a period transfers on any edge where cfg_valid and
  // cfg_ready are both high; cfg_valid/cfg_period must hold until then.
  assign cfg_ready  = (state_q == S_IDLE) || !pending_valid_q;
  assign xfer       = cfg_valid && cfg_ready;
  // A period of 0 is treated as 1, so the terminal count is 0 in both cases.
  assign last_count = (period_q == 32'd0) ? 32'd0 : (period_q - 32'd1);

  always_comb begin
    state_d          = state_q;
    counter_d        = counter_q;
    period_d         = period_q;
    pending_period_d = pending_period_q;
    pending_valid_d  = pending_valid_q;
    shot_mode_d      = shot_mode_q;
    tick_count_d     = tick_count_q;
    tick_d           = 1'b0;
    done_d           = 1'b0;

    if (stop || start) begin
      // Both commands flush the pending period; a same-edge offer is newest.
      if (xfer) begin
        period_d = cfg_period;
      end else if (pending_valid_q) begin
        period_d = pending_period_q;
      end
      pending_valid_d = 1'b0;
      counter_d       = 32'd0;
      if (stop) begin
        state_d = S_IDLE;
      end else begin
        state_d      = S_RUN;
        tick_count_d = '0;
        shot_mode_d  = one_shot;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            period_d        = cfg_period;
            pending_valid_d = 1'b0;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (counter_q == last_count) begin
            counter_d    = 32'd0;
            tick_d       = 1'b1;
            tick_count_d = tick_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            if (pending_valid_q) begin
              period_d        = pending_period_q;
              pending_valid_d = 1'b0;
            end
            if (shot_mode_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            counter_d = counter_q + 32'd1;
          end
          // An offer accepted on a boundary waits for the following boundary.
          if (xfer) begin
            pending_period_d = cfg_period;
            pending_valid_d  = 1'b1;
          end
        end
        S_PAUSE: begin
          if (!pause) begin
            state_d = S_RUN;
          end
          if (xfer) begin
            pending_period_d = cfg_period;
            pending_valid_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      counter_q        <= 32'd0;
      period_q         <= DEFAULT_PERIOD;
      pending_period_q <= 32'd0;
      pending_valid_q  <= 1'b0;
      shot_mode_q      <= 1'b0;
      tick_q           <= 1'b0;
      done_q           <= 1'b0;
      tick_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      counter_q        <= counter_d;
      period_q         <= period_d;
      pending_period_q <= pending_period_d;
      pending_valid_q  <= pending_valid_d;
      shot_mode_q      <= shot_mode_d;
      tick_q           <= tick_d;
      done_q           <= done_d;
      tick_count_q     <= tick_count_d;
    end
  end

  assign tick       = tick_q;
  assign done       = done_q;
  assign running    = (state_q == S_RUN);
  assign paused     = (state_q == S_PAUSE);
  assign period     = period_q;
  assign tick_count = tick_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed testbench for tick_scheduler: each task drives one scenario and
// checks outputs one time unit after the rising edge.
module tb_tick_scheduler;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic        pause;
  logic        one_shot;
  logic        cfg_valid;
  logic [31:0] cfg_period;
  logic        cfg_ready;
  logic        tick;
  logic        done;
  logic        running;
  logic        paused;
  logic [31:0] period;
  logic [15:0] tick_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  tick_scheduler #(
    .DEFAULT_PERIOD(32'd50_000_000),
    .COUNT_W       (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .one_shot  (one_shot),
    .cfg_valid (cfg_valid),
    .cfg_period(cfg_period),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .done      (done),
    .running   (running),
    .paused    (paused),
    .period    (period),
    .tick_count(tick_count),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic load_period(input logic [31:0] p);
    cfg_valid  = 1'b1;
    cfg_period = p;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic do_start(input logic shot);
    one_shot = shot;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (tick !== 1'b0) begin $display("FAIL reset_tick got=%b exp=0", tick); errors++; end
    checks++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", done); errors++; end
    checks++; if (running !== 1'b0 || paused !== 1'b0) begin $display("FAIL reset_state got=%b%b exp=00", running, paused); errors++; end
    checks++; if (cfg_ready !== 1'b1) begin $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); errors++; end
    checks++; if (period !== 32'd50_000_000) begin $display("FAIL reset_period got=%0d exp=50000000", period); errors++; end
    checks++; if (tick_count !== 16'd0) begin $display("FAIL reset_tick_count got=%0d exp=0", tick_count); errors++; end
    checks++; if (dbg_state !== 2'd0) begin $display("FAIL reset_dbg_state got=%0d exp=0", dbg_state); errors++; end
  endtask

  task automatic test_periodic();
    logic exp_t;
    load_period(32'd4);
    checks++; if (period !== 32'd4) begin $display("FAIL idle_cfg_period got=%0d exp=4", period); errors++; end
    do_start(1'b0);
    checks++; if (running !== 1'b1 || tick !== 1'b0) begin $display("FAIL start_run got run=%b tick=%b exp run=1 tick=0", running, tick); errors++; end
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_t = ((i % 4) == 0);
      checks++; if (tick !== exp_t) begin $display("FAIL periodic_tick edge=%0d got=%b exp=%b", i, tick, exp_t); errors++; end
    end
    checks++; if (tick_count !== 16'd3) begin $display("FAIL periodic_count got=%0d exp=3", tick_count); errors++; end
    checks++; if (running !== 1'b1) begin $display("FAIL periodic_running got=%b exp=1", running); errors++; end
  endtask

  task automatic test_config();
    do_stop();
    checks++; if (tick_count !== 16'd3 || running !== 1'b0) begin $display("FAIL stop_hold got cnt=%0d run=%b exp cnt=3 run=0", tick_count, running); errors++; end
    load_period(32'd5);
    do_start(1'b0);
    step();
    step();
    checks++; if (cfg_ready !== 1'b1) begin $display("FAIL cfg_ready_free got=%b exp=1", cfg_ready); errors++; end
    cfg_valid  = 1'b1;
    cfg_period = 32'd2;
    step();                                   // edge 3: accepted, pending
    cfg_period = 32'd3;                       // second offer, must stall
    checks++; if (cfg_ready !== 1'b0 || period !== 32'd5) begin $display("FAIL cfg_pending got rdy=%b per=%0d exp rdy=0 per=5", cfg_ready, period); errors++; end
    step();                                   // edge 4
    checks++; if (tick !== 1'b0 || cfg_ready !== 1'b0) begin $display("FAIL cfg_edge4 got tick=%b rdy=%b exp 0 0", tick, cfg_ready); errors++; end
    step();                                   // edge 5: boundary, period -> 2
    checks++; if (tick !== 1'b1 || period !== 32'd2 || cfg_ready !== 1'b1) begin $display("FAIL cfg_edge5 got tick=%b per=%0d rdy=%b exp 1 2 1", tick, period, cfg_ready); errors++; end
    step();                                   // edge 6: second offer accepted
    cfg_valid = 1'b0;
    checks++; if (tick !== 1'b0 || cfg_ready !== 1'b0 || period !== 32'd2) begin $display("FAIL cfg_edge6 got tick=%b rdy=%b per=%0d exp 0 0 2", tick, cfg_ready, period); errors++; end
    step();                                   // edge 7: boundary with E=2, period -> 3
    checks++; if (tick !== 1'b1 || period !== 32'd3) begin $display("FAIL cfg_edge7 got tick=%b per=%0d exp 1 3", tick, period); errors++; end
    step();
    step();
    checks++; if (tick !== 1'b0) begin $display("FAIL cfg_edge9 got=%b exp=0", tick); errors++; end
    step();                                   // edge 10: boundary with E=3
    checks++; if (tick !== 1'b1) begin $display("FAIL cfg_edge10 got=%b exp=1", tick); errors++; end
  endtask

  task automatic test_pause();
    int pause_ticks;
    int pause_flag_bad;
    do_stop();
    load_period(32'd6);
    do_start(1'b0);
    step(); step(); step();                   // counter = 3
    pause = 1'b1;
    pause_ticks    = 0;
    pause_flag_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick !== 1'b0) pause_ticks++;
      if (paused !== 1'b1 || running !== 1'b0) pause_flag_bad++;
    end
    pause = 1'b0;
    checks++; if (pause_ticks !== 0) begin $display("FAIL pause_ticks got=%0d exp=0", pause_ticks); errors++; end
    checks++; if (pause_flag_bad !== 0) begin $display("FAIL pause_flag bad_cycles=%0d exp=0", pause_flag_bad); errors++; end
    step();                                   // resume edge
    checks++; if (running !== 1'b1 || paused !== 1'b0 || tick !== 1'b0) begin $display("FAIL resume got run=%b pau=%b tick=%b exp 1 0 0", running, paused, tick); errors++; end
    step();
    step();
    checks++; if (tick !== 1'b0) begin $display("FAIL resume_early got=%b exp=0", tick); errors++; end
    step();
    checks++; if (tick !== 1'b1) begin $display("FAIL resume_tick got=%b exp=1", tick); errors++; end
  endtask

  task automatic test_one_shot();
    int extra;
    do_stop();
    load_period(32'd3);
    do_start(1'b1);
    one_shot = 1'b0;
    step();
    step();
    checks++; if (tick !== 1'b0 || done !== 1'b0 || running !== 1'b1) begin $display("FAIL shot_pre got tick=%b done=%b run=%b exp 0 0 1", tick, done, running); errors++; end
    step();
    checks++; if (tick !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin $display("FAIL shot_end got tick=%b done=%b run=%b exp 1 1 0", tick, done, running); errors++; end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick !== 1'b0 || done !== 1'b0) extra++;
    end
    checks++; if (extra !== 0) begin $display("FAIL shot_quiet got=%0d exp=0", extra); errors++; end
    checks++; if (tick_count !== 16'd1) begin $display("FAIL shot_count got=%0d exp=1", tick_count); errors++; end
  endtask

  task automatic test_zero_period_stop();
    load_period(32'd0);
    do_start(1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (tick !== 1'b1) begin $display("FAIL zero_tick edge=%0d got=%b exp=1", i, tick); errors++; end
    end
    checks++; if (tick_count !== 16'd4) begin $display("FAIL zero_count got=%0d exp=4", tick_count); errors++; end
    do_stop();                                // boundary edge: tick suppressed
    checks++; if (tick !== 1'b0 || running !== 1'b0 || tick_count !== 16'd4) begin $display("FAIL zero_stop got tick=%b run=%b cnt=%0d exp 0 0 4", tick, running, tick_count); errors++; end
  endtask

  task automatic test_back_to_back();
    load_period(32'd4);
    do_start(1'b0);
    step(); step();
    do_start(1'b0);                           // restart mid-interval
    checks++; if (tick_count !== 16'd0 || running !== 1'b1) begin $display("FAIL restart got cnt=%0d run=%b exp 0 1", tick_count, running); errors++; end
    step(); step(); step();
    checks++; if (tick !== 1'b0) begin $display("FAIL restart_early got=%b exp=0", tick); errors++; end
    step();
    checks++; if (tick !== 1'b1 || tick_count !== 16'd1) begin $display("FAIL restart_tick got tick=%b cnt=%0d exp 1 1", tick, tick_count); errors++; end
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checks++; if (running !== 1'b0 || dbg_state !== 2'd0) begin $display("FAIL start_stop got run=%b st=%0d exp 0 0", running, dbg_state); errors++; end
  endtask

  task automatic test_reset_mid_run();
    load_period(32'd10);
    do_start(1'b0);
    step(); step();
    load_period(32'd7);
    checks++; if (cfg_ready !== 1'b0) begin $display("FAIL mid_pending got=%b exp=0", cfg_ready); errors++; end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (period !== 32'd50_000_000 || cfg_ready !== 1'b1) begin $display("FAIL mid_reset got per=%0d rdy=%b exp 50000000 1", period, cfg_ready); errors++; end
    checks++; if (tick !== 1'b0 || done !== 1'b0 || running !== 1'b0) begin $display("FAIL mid_reset_out got tick=%b done=%b run=%b exp 0 0 0", tick, done, running); errors++; end
    do_start(1'b0);
    step();
    checks++; if (cfg_ready !== 1'b1 || period !== 32'd50_000_000) begin $display("FAIL mid_discard got rdy=%b per=%0d exp 1 50000000", cfg_ready, period); errors++; end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    pause      = 1'b0;
    one_shot   = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = 32'd0;
    test_reset();
    test_periodic();
    test_config();
    test_pause();
    test_one_shot();
    test_zero_period_stop();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
